imem_loader: RTL
================

// Module: imem_loader
// PURPOSE
//  Write-side companion of the word-indexed instruction memory: receives a program image as a byte stream.
//  Assembles big-endian 32-bit instruction words and drives the memory write port at word addresses 0,1,2,...
//  Verifies a trailing checksum byte. Holds the core in reset (core_hold) while an image is being loaded.
// PARAMETERS
//  ADDR_WIDTH  6   word-address width; memory depth DEPTH = 2**ADDR_WIDTH (64 words)
// PORTS
//  clk        in   1             system clock, all logic on rising edge
//  rst_n      in   1             asynchronous, active-low reset
//  start      in   1             1-cycle pulse: begin a load; ignored while busy
//  num_words  in   ADDR_WIDTH+1  word count for this image, sampled on accepted start
//  rx_data    in   8             image byte
//  rx_valid   in   1             rx_data valid
//  rx_ready   out  1             loader accepts byte when rx_valid & rx_ready
//  wr_en      out  1             instruction memory write strobe, 1 cycle per word
//  wr_addr    out  ADDR_WIDTH    word address (same index as the PC-side read)
//  wr_data    out  32            assembled instruction word
//  busy       out  1             load in progress (LOAD or CHECK)
//  done       out  1             sticky: last load finished with good checksum
//  error      out  1             sticky: last load finished with bad checksum
//  core_hold  out  1             keep core in reset
// BEHAVIOUR
//  Reset: all outputs 0. State IDLE. Counters, checksum and byte buffer cleared.
//  Reset mid-load aborts immediately; any partial word is discarded. Words already written stay in memory.
//  FSM: IDLE -> LOAD -> CHECK -> IDLE.
//  IDLE: rx_ready=0. On start:
//   - latch N = min(num_words, DEPTH); clear done, error, sum, byte_cnt, word_cnt.
//   - next state LOAD, or CHECK if N==0.
//  LOAD: rx_ready=1.
//   - Each accepted byte shifts into a 32-bit buffer MSB-first: buf <= {buf[23:0], rx_data}.
//   - Each accepted byte is added to sum (8-bit, modulo 256).
//   - On the 4th byte of a word, the next cycle drives wr_en=1, wr_addr=word_cnt, wr_data=assembled word.
//   - word_cnt then increments.
//   - Write latency: 1 cycle after the accepting edge. wr_en is never high two cycles for the same word.
//   - After the Nth word's 4th byte is accepted -> CHECK. That word's write still issues in the following cycle.
//  CHECK: rx_ready=1. Next accepted byte is the checksum C; return to IDLE.
//   - done=1 if (sum + C) mod 256 == 0, else error=1.
//  rx_valid with rx_ready=0 is ignored; no byte is consumed in IDLE.
//  wr_addr never exceeds DEPTH-1. Clamping N prevents address wrap-around.
//  busy=1 in LOAD/CHECK. core_hold=1 in LOAD/CHECK, and stays 1 after error until the next good load.
//  core_hold=0 after done.
//  start asserted during LOAD/CHECK has no effect; num_words changes after start have no effect.
//  done/error are mutually exclusive and hold until the next accepted start.
// TESTING
//  1. Reset, start num_words=2, bytes 01 2A 40 20 01 2A 40 23 E7 ->
//     writes (0,0x012A4020) then (1,0x012A4023); done=1, error=0, core_hold=0.
//  2. Same image, checksum byte E6 -> both words still written; error=1, done=0, core_hold stays 1.
//  3. Random rx_valid gaps plus start pulse mid-LOAD -> identical write sequence to case 1.
//     Start pulse ignored; no extra writes.
//  4. num_words=100 (>64), 64*4 bytes + checksum ->
//     exactly 64 writes, addresses 0..63 in order, no wrap to 0; rx_ready=1 in CHECK.
//  5. num_words=0, byte 00 -> no wr_en; done=1. Byte 01 instead -> error=1.
//  6. rst_n low after 6 bytes of case 1 -> all outputs 0 asynchronously; exactly one write (addr 0) occurred.
//     A fresh start then loads correctly.

Source files
------------

// File: rtl/imem_loader_if.sv
// Byte-stream and memory-write bundle between a program-image source and
// the instruction-memory loader. The master side feeds bytes and starts
// loads. The slave side (the loader) drives the memory write port and the
// status flags.
interface imem_loader_if #(
    parameter int ADDR_WIDTH = 6
);
    logic                  start;
    logic [ADDR_WIDTH:0]   num_words;
    logic [7:0]            rx_data;
    logic                  rx_valid;
    logic                  rx_ready;
    logic                  wr_en;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [31:0]           wr_data;
    logic                  busy;
    logic                  done;
    logic                  error;
    logic                  core_hold;

    modport master (
        output start, num_words, rx_data, rx_valid,
        input  rx_ready, wr_en, wr_addr, wr_data, busy, done, error, core_hold
    );

    modport slave (
        input  start, num_words, rx_data, rx_valid,
        output rx_ready, wr_en, wr_addr, wr_data, busy, done, error, core_hold
    );
endinterface

// File: rtl/imem_loader.sv
// Instruction-memory loader. It receives a program image as a byte stream
// and packs it into big-endian 32-bit words. Each word is written to word
// addresses 0, 1, 2, ... in order. A trailing checksum byte is then checked.
// The core is held in reset while a load runs, and after a load that failed
// its checksum.
module imem_loader #(
    parameter int ADDR_WIDTH = 6
) (
    input  logic clk,
    input  logic rst_n,
    imem_loader_if.slave bus
);
    localparam logic [ADDR_WIDTH:0] DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] LOAD  = 2'd1;
    localparam logic [1:0] CHECK = 2'd2;

    logic [1:0]            state;
    logic [ADDR_WIDTH:0]   n_words;
    logic [ADDR_WIDTH:0]   word_cnt;
    logic [1:0]            byte_cnt;
    logic [23:0]           shift_buf;
    logic [7:0]            sum;
    logic [7:0]            final_sum;
    logic                  accept;
    logic                  in_load;
    logic                  wr_en_q;
    logic [ADDR_WIDTH-1:0] wr_addr_q;
    logic [31:0]           wr_data_q;
    logic                  done_q;
    logic                  error_q;

    // Only the first three bytes of a word need buffering. The fourth byte
    // goes straight into the write data.
    assign in_load   = (state != IDLE);
    assign accept    = bus.rx_valid & in_load;
    assign final_sum = sum + bus.rx_data;

    // Sequence one image: latch the clamped word count, assemble and write
    // the words, then judge the checksum byte.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            n_words   <= '0;
            word_cnt  <= '0;
            byte_cnt  <= '0;
            shift_buf <= '0;
            sum       <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            done_q    <= 1'b0;
            error_q   <= 1'b0;
        end else begin
            wr_en_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        n_words  <= (bus.num_words > DEPTH) ? DEPTH : bus.num_words;
                        done_q   <= 1'b0;
                        error_q  <= 1'b0;
                        sum      <= '0;
                        byte_cnt <= '0;
                        word_cnt <= '0;
                        state    <= (bus.num_words == '0) ? CHECK : LOAD;
                    end
                end
                LOAD: begin
                    if (accept) begin
                        shift_buf <= {shift_buf[15:0], bus.rx_data};
                        sum       <= final_sum;
                        byte_cnt  <= byte_cnt + 2'd1;
                        if (byte_cnt == 2'd3) begin
                            wr_en_q   <= 1'b1;
                            wr_addr_q <= word_cnt[ADDR_WIDTH-1:0];
                            wr_data_q <= {shift_buf, bus.rx_data};
                            word_cnt  <= word_cnt + 1'b1;
                            if (word_cnt + 1'b1 == n_words) begin
                                state <= CHECK;
                            end
                        end
                    end
                end
                CHECK: begin
                    if (accept) begin
                        if (final_sum == 8'd0) begin
                            done_q <= 1'b1;
                        end else begin
                            error_q <= 1'b1;
                        end
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // error stays set until the next accepted start. So holding the core on
    // busy-or-error keeps it held until a later load succeeds.
    assign bus.rx_ready  = in_load;
    assign bus.busy      = in_load;
    assign bus.core_hold = in_load | error_q;
    assign bus.done      = done_q;
    assign bus.error     = error_q;
    assign bus.wr_en     = wr_en_q;
    assign bus.wr_addr   = wr_addr_q;
    assign bus.wr_data   = wr_data_q;
endmodule
